// File: rtl/store_rmw_if.sv
// Store request / data RAM bundle for store_rmw_unit.
// slave is the store unit; master is the pipeline-plus-RAM side driving it.
interface store_rmw_if #(
    parameter int ADDR_W = 32
);
    logic              req;
    logic [2:0]        MemWrite;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata_in;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic [31:0]       mem_rdata;
    logic              mem_we;
    logic [31:0]       mem_wdata;

    modport slave (
        input  req, MemWrite, addr, wdata_in, mem_rdata,
        output busy, done, err, mem_addr, mem_re, mem_we, mem_wdata
    );

    modport master (
        output req, MemWrite, addr, wdata_in, mem_rdata,
        input  busy, done, err, mem_addr, mem_re, mem_we, mem_wdata
    );
endinterface

// File: rtl/store_rmw_unit.sv
// Byte/half/word store engine for a RAM without byte enables: aligned words are
// written directly, partial stores go through read, merge, write-back.
module store_rmw_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    store_rmw_if.slave    bus
);
    localparam logic [2:0] OP_SB = 3'b001;
    localparam logic [2:0] OP_SH = 3'b010;
    localparam logic [2:0] OP_SW = 3'b011;

    typedef enum logic [2:0] {IDLE, RD, MRG, WR, FIN} state_t;

    state_t             state;
    logic [1:0]         w_q;
    logic [15:0]        data_q;
    logic               sb_q;
    logic [DATA_W-1:0]  merged;
    logic [1:0]         w_in;

    assign w_in     = bus.addr[1:0];
    assign bus.busy = (state != IDLE);

    // Untouched lanes come from the word just read back.
    always_comb begin
        merged = bus.mem_rdata;
        if (sb_q) begin
            case (w_q)
                2'd0:    merged[7:0]   = data_q[7:0];
                2'd1:    merged[15:8]  = data_q[7:0];
                2'd2:    merged[23:16] = data_q[7:0];
                default: merged[31:24] = data_q[7:0];
            endcase
        end else begin
            case (w_q)
                2'd0:    merged[15:0]  = data_q;
                2'd1:    merged[23:8]  = data_q;
                default: merged[31:16] = data_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            w_q           <= '0;
            data_q        <= '0;
            sb_q          <= 1'b0;
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
            bus.mem_re    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    bus.err  <= 1'b0;
                    if (bus.req) begin
                        w_q          <= w_in;
                        data_q       <= bus.wdata_in[15:0];
                        sb_q         <= (bus.MemWrite == OP_SB);
                        bus.mem_addr <= {bus.addr[ADDR_W-1:2], 2'b00};
                        if (bus.MemWrite == OP_SW && w_in == 2'd0) begin
                            bus.mem_wdata <= bus.wdata_in;
                            bus.mem_we    <= 1'b1;
                            state         <= WR;
                        end else if (bus.MemWrite == OP_SB ||
                                     (bus.MemWrite == OP_SH && w_in != 2'd3)) begin
                            bus.mem_re <= 1'b1;
                            state      <= RD;
                        end else begin
                            // Misaligned or unknown op: report without touching memory.
                            bus.done <= 1'b1;
                            bus.err  <= 1'b1;
                            state    <= FIN;
                        end
                    end
                end
                RD: begin
                    bus.mem_re <= 1'b0;
                    state      <= MRG;
                end
                MRG: begin
                    bus.mem_wdata <= merged;
                    bus.mem_we    <= 1'b1;
                    state         <= WR;
                end
                WR: begin
                    bus.mem_we <= 1'b0;
                    bus.done   <= 1'b1;
                    bus.err    <= 1'b0;
                    state      <= FIN;
                end
                default: begin
                    bus.done <= 1'b0;
                    bus.err  <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_store_rmw_unit.sv
// Bench for store_rmw_unit: directed plan steps plus random stores checked
// against a byte-level memory model and a latency table.
module tb_store_rmw_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    store_rmw_if #(.ADDR_W(32)) ifc ();
    store_rmw_unit #(.ADDR_W(32), .DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(ifc.slave));

    int ncmp = 0;
    int nerr = 0;

    logic [31:0] ram     [0:1023];
    logic [31:0] ref_mem [0:1023];
    logic        pre_en = 1'b0;
    logic [9:0]  pre_idx = '0;
    logic [31:0] pre_val = '0;
    int          we_cnt = 0, re_cnt = 0, overlap = 0;

    // Synchronous RAM without byte enables; read data appears the cycle after mem_re.
    always @(posedge clk) begin
        if (pre_en) ram[pre_idx] <= pre_val;
        else if (ifc.mem_we) ram[ifc.mem_addr[11:2]] <= ifc.mem_wdata;
        if (ifc.mem_re) ifc.mem_rdata <= ram[ifc.mem_addr[11:2]];
        if (ifc.mem_we) we_cnt <= we_cnt + 1;
        if (ifc.mem_re) re_cnt <= re_cnt + 1;
        if (ifc.mem_re && ifc.mem_we) overlap <= overlap + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] v);
        @(negedge clk);
        pre_en = 1'b1; pre_idx = a[11:2]; pre_val = v;
        ref_mem[a[11:2]] = v;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    // Reference: returns 1 for a rejected store, else updates ref_mem byte by byte.
    function automatic bit ref_store(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
        int size, w;
        logic [31:0] word;
        size = (op == 3'd1) ? 1 : (op == 3'd2) ? 2 : (op == 3'd3) ? 4 : 0;
        w = int'(a[1:0]);
        if (size == 0 || w + size > 4 || (size == 4 && w != 0)) return 1'b1;
        word = ref_mem[a[11:2]];
        for (int i = 0; i < size; i++) begin
            word = (word & ~(32'hFF << (8 * (w + i)))) | (((d >> (8 * i)) & 32'hFF) << (8 * (w + i)));
        end
        ref_mem[a[11:2]] = word;
        return 1'b0;
    endfunction

    task automatic run_store(input string tag, input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] d, input bit scramble);
        int k_re = -1, k_we = -1, k_done = -1, n_done = 0, n_we = 0;
        int e_re, e_we, e_done;
        logic err_seen = 1'b0;
        logic [31:0] wa = '0, wd = '0;
        bit rej;
        rej = ref_store(op, a, d);
        if (rej) begin e_re = -1; e_we = -1; e_done = 1; end
        else if (op == 3'd3) begin e_re = -1; e_we = 1; e_done = 2; end
        else begin e_re = 1; e_we = 3; e_done = 4; end
        @(negedge clk);
        ifc.req = 1'b1; ifc.MemWrite = op; ifc.addr = a; ifc.wdata_in = d;
        @(posedge clk);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (ifc.mem_re && k_re < 0) k_re = k;
            if (ifc.mem_we) begin
                n_we++;
                if (k_we < 0) k_we = k;
                wa = ifc.mem_addr; wd = ifc.mem_wdata;
            end
            if (ifc.done) begin
                n_done++;
                if (k_done < 0) begin k_done = k; err_seen = ifc.err; end
            end
            ifc.req = 1'b0;
            if (scramble) begin
                ifc.addr = $urandom; ifc.wdata_in = $urandom; ifc.MemWrite = 3'($urandom);
            end
        end
        chk({tag, " re_cycle"}, k_re, e_re);
        chk({tag, " we_cycle"}, k_we, e_we);
        chk({tag, " done_cycle"}, k_done, e_done);
        chk({tag, " done_count"}, n_done, 1);
        chk({tag, " err"}, {31'd0, err_seen}, {31'd0, rej});
        chk({tag, " busy_after"}, {31'd0, ifc.busy}, 32'd0);
        if (!rej) begin
            chk({tag, " we_count"}, n_we, 1);
            chk({tag, " wr_addr"}, wa, {a[31:2], 2'b00});
            chk({tag, " wr_data"}, wd, ref_mem[a[11:2]]);
            chk({tag, " ram"}, ram[a[11:2]], ref_mem[a[11:2]]);
        end
    endtask

    initial begin
        int b_we, b_re, n_done;
        int dcyc [$];
        bit r;
        logic [2:0] op;
        logic [31:0] a;
        ifc.req = 1'b0; ifc.MemWrite = 3'd0; ifc.addr = '0; ifc.wdata_in = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst busy", {31'd0, ifc.busy}, 32'd0);
        chk("rst done", {30'd0, ifc.done, ifc.err}, 32'd0);
        chk("rst strobes", {30'd0, ifc.mem_re, ifc.mem_we}, 32'd0);
        chk("rst mem_addr", ifc.mem_addr, 32'd0);
        chk("rst mem_wdata", ifc.mem_wdata, 32'd0);
        rst = 1'b0;

        // Directed plan steps
        run_store("sw100", 3'd3, 32'h100, 32'hDEADBEEF, 1'b0);
        preload(32'h200, 32'h11223344);
        run_store("sb202", 3'd1, 32'h202, 32'hFFFFFFAA, 1'b0);
        chk("sb202 word", ram[32'h200 >> 2], 32'h11AA3344);
        preload(32'h200, 32'h11223344);
        run_store("sh201", 3'd2, 32'h201, 32'h0000BEEF, 1'b1);
        chk("sh201 word", ram[32'h200 >> 2], 32'h11BEEF44);
        preload(32'h200, 32'h11223344);
        run_store("sh202", 3'd2, 32'h202, 32'h00005566, 1'b0);
        chk("sh202 word", ram[32'h200 >> 2], 32'h55663344);
        run_store("sh203", 3'd2, 32'h203, 32'h1234, 1'b0);
        run_store("sw102", 3'd3, 32'h102, 32'h1234, 1'b0);
        run_store("op7", 3'd7, 32'h100, 32'h1234, 1'b0);

        // Back-to-back: req held high, sb then sw; requests while busy are dropped.
        preload(32'h400, 32'hCAFEF00D);
        preload(32'h404, 32'h0);
        r = ref_store(3'd1, 32'h401, 32'h77);
        r = ref_store(3'd3, 32'h404, 32'h89ABCDEF);
        b_we = we_cnt; b_re = re_cnt; n_done = 0;
        @(negedge clk);
        ifc.req = 1'b1; ifc.MemWrite = 3'd1; ifc.addr = 32'h401; ifc.wdata_in = 32'h77;
        @(posedge clk);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (ifc.done) begin n_done++; dcyc.push_back(k); end
            if (k == 1) begin ifc.MemWrite = 3'd3; ifc.addr = 32'h404; ifc.wdata_in = 32'h89ABCDEF; end
            if (k == 6) ifc.req = 1'b0;
        end
        chk("b2b done_count", n_done, 2);
        chk("b2b done1", (dcyc.size() > 0) ? dcyc[0] : -1, 4);
        chk("b2b done2", (dcyc.size() > 1) ? dcyc[1] : -1, 7);
        chk("b2b writes", we_cnt - b_we, 2);
        chk("b2b reads", re_cnt - b_re, 1);
        chk("b2b ram0", ram[32'h400 >> 2], ref_mem[32'h400 >> 2]);
        chk("b2b ram1", ram[32'h404 >> 2], ref_mem[32'h404 >> 2]);

        // Reset while in MRG: write must never happen, no done.
        preload(32'h300, 32'hA5A5A5A5);
        b_we = we_cnt; n_done = 0;
        @(negedge clk);
        ifc.req = 1'b1; ifc.MemWrite = 3'd1; ifc.addr = 32'h300; ifc.wdata_in = 32'h5A;
        @(posedge clk);
        @(negedge clk); ifc.req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mrst busy", {31'd0, ifc.busy}, 32'd0);
        chk("mrst flags", {28'd0, ifc.done, ifc.err, ifc.mem_re, ifc.mem_we}, 32'd0);
        chk("mrst mem_addr", ifc.mem_addr, 32'd0);
        chk("mrst mem_wdata", ifc.mem_wdata, 32'd0);
        @(negedge clk); rst = 1'b0;
        repeat (5) begin @(negedge clk); if (ifc.done) n_done++; end
        chk("mrst no_done", n_done, 0);
        chk("mrst no_write", we_cnt - b_we, 0);
        chk("mrst ram", ram[32'h300 >> 2], 32'hA5A5A5A5);
        run_store("post_rst_sw", 3'd3, 32'h300, 32'h0BADF00D, 1'b0);

        // Random stores with inputs scrambled while busy.
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 4))
                0: op = 3'd1;
                1: op = 3'd2;
                2, 3: op = 3'd3;
                default: op = 3'($urandom_range(4, 7));
            endcase
            a = $urandom;
            if (op == 3'd3 && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            preload(a, $urandom);
            run_store("rnd", op, a, $urandom, 1'b1);
        end
        chk("re_we_overlap", overlap, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/store_rmw_unit.md
Name: store_rmw_unit

Overview:
- Store-side counterpart of the load data extractor: takes a CPU store request (sb/sh/sw), aligns the source data to the correct byte lanes and writes it to a word-wide data memory that has no byte enables.
- Partial stores use a read-modify-write sequence: read the word, merge the new bytes, write the word back.
- Sits between the EX/MEM store path and the synchronous data RAM. It holds `busy` high so the pipeline stalls until the store finishes.

Parameters:
- ADDR_W, 32, byte-address width of `addr` and `mem_addr`.
- DATA_W, 32, memory word width. Fixed at 32; other values are unsupported.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  1  store request, sampled only in IDLE.
- MemWrite  input  3  store op: 3'b001 sb, 3'b010 sh, 3'b011 sw; all other codes are invalid.
- addr  input  ADDR_W  byte address of the store.
- wdata_in  input  32  source register value; low byte/half/word is stored.
- busy  output  1  high while a store is in progress (state != IDLE).
- done  output  1  one-cycle pulse when the store completes or is rejected.
- err  output  1  one-cycle pulse, coincident with `done`, for a misaligned or invalid op.
- mem_addr  output  ADDR_W  word address sent to RAM, {addr_q[ADDR_W-1:2],2'b00}.
- mem_re  output  1  RAM read strobe.
- mem_rdata  input  32  RAM read data, valid the cycle after `mem_re`.
- mem_we  output  1  RAM write strobe.
- mem_wdata  output  32  merged word to write.

Behaviour:
- All outputs are registered or decoded from state. On reset: state=IDLE, busy=0, done=0, err=0, mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Lane offset: w = addr_q[1:0].
- States: IDLE, RD, MRG, WR, FIN.
- IDLE:
  - On req=1, latch addr_q, data_q, op_q.
  - Valid sw with w=0 -> WR; mem_wdata is loaded with data_q at the WR entry edge.
  - Valid sb (any w), or valid sh with w in {0,1,2} -> RD.
  - sw with w!=0, sh with w=3, or an invalid op -> FIN with err flagged. No memory access occurs.
  - req=0 -> stay in IDLE.
- RD: mem_re=1 for exactly one cycle -> MRG.
- MRG:
  - Sample mem_rdata and build the merged word, keeping untouched lanes from mem_rdata:
    - sb: lane w <= data_q[7:0].
    - sh w=0: [15:0] <= data_q[15:0].
    - sh w=1: [23:8] <= data_q[15:0].
    - sh w=2: [31:16] <= data_q[15:0].
  - Register the result into mem_wdata -> WR.
- WR: mem_we=1 for exactly one cycle; mem_addr and mem_wdata are stable -> FIN.
- FIN: done=1 (err=1 if flagged) for one cycle -> IDLE. busy is still 1 in FIN and 0 the next cycle.
- Latency from the req edge T:
  - sw: WR at T+1, done at T+2.
  - sb/sh: RD at T+1, MRG at T+2, WR at T+3, done at T+4.
  - Rejected op: done+err at T+1.
- req while busy=1 is ignored; it is not queued. A new req is accepted the first cycle back in IDLE, with no bubble required after FIN.
- mem_re and mem_we are never high in the same cycle. mem_addr is held from the acceptance edge until IDLE.
- Reset asserted mid-operation: outputs clear immediately and asynchronously, and mem_we drops in the same cycle.
  - A write in flight during a reset in RD/MRG never occurs.
  - No done pulse is issued.
- Inputs are don't-care outside the IDLE acceptance cycle. Changing addr/wdata_in during busy must not affect the result.

Test Plan:
- Reset, then sw addr=0x100 data=0xDEADBEEF -> at T+1 mem_we=1, mem_addr=0x100, mem_wdata=0xDEADBEEF; at T+2 done=1, err=0; mem_re never asserted.
- RAM word 0x11223344 at 0x200; sb addr=0x202 data=0xFFFFFFAA -> RD at T+1, mem_wdata=0x11AA3344 written at T+3, done at T+4.
- Same RAM word; sh addr=0x201 data=0x0000BEEF -> written 0x11BEEF44. sh addr=0x202 data=0x5566 -> written 0x55663344.
- sh addr=0x203 and sw addr=0x102 and MemWrite=3'b111 -> each gives done=err=1 at T+1 with mem_re=mem_we=0 throughout.
- Back-to-back: req held high with sb then sw -> second store accepted the cycle after FIN; the req pulse during busy does not start an extra access; RAM shows both writes in order.
- sb started, rst pulsed while in MRG -> all outputs 0 at once, RAM word unchanged, no done pulse; next sw completes normally.
